// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage and its halfword cache.
package inst_fetcher_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOK_LO  = 3'd1,
        S_MISS_LO0 = 3'd2,
        S_MISS_LO1 = 3'd3,
        S_LOOK_HI  = 3'd4,
        S_MISS_HI0 = 3'd5,
        S_MISS_HI1 = 3'd6,
        S_FLUSH    = 3'd7
    } fetch_state_e;

    localparam logic [1:0] RVC_LOW_BITS = 2'b11;
    localparam int         HW_W         = 16;
    localparam int         BYTE_W       = 8;

    // An instruction is compressed unless its two lowest bits are both set.
    function automatic logic is_rvc(input logic [1:0] low_bits);
        return (low_bits != RVC_LOW_BITS);
    endfunction

endpackage

// File: rtl/icache_hw.sv
// Direct-mapped halfword instruction cache: combinational lookup, registered fill,
// with write-first forwarding when a fill and a lookup hit the same index.
module icache_hw
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-2:0] rd_hw,
    output logic              rd_hit,
    output logic [HW_W-1:0]   rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-2:0] wr_hw,
    input  logic [HW_W-1:0]   wr_data
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    logic [DEPTH-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [DEPTH];
    logic [HW_W-1:0]   data_r [DEPTH];

    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [TAG_W-1:0]  wr_tag_s;

    assign rd_idx_s = rd_hw[IDX_W-1:0];
    assign rd_tag_s = rd_hw[ADDR_W-2:IDX_W];
    assign wr_idx_s = wr_hw[IDX_W-1:0];
    assign wr_tag_s = wr_hw[ADDR_W-2:IDX_W];

    // Lookup; a fill landing on the same index this cycle replaces the stored entry.
    always_comb begin
        if (wr_en && (wr_idx_s == rd_idx_s)) begin
            rd_hit  = (wr_tag_s == rd_tag_s);
            rd_data = wr_data;
        end else begin
            rd_hit  = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
            rd_data = data_r[rd_idx_s];
        end
    end

    // Valid bits are the only cache state that reset must clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a completed fill.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_r[wr_idx_s]  <= wr_tag_s;
            data_r[wr_idx_s] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: resolves one instruction per decoder request from the halfword cache,
// refilling misses byte by byte from the memory controller.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              inst_ready,
    output logic              is_c,
    output logic [31:0]       inst_val,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_byte
);

    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO  = ADDR_W'(2);
    localparam logic [ADDR_W-2:0] HW_ONE = (ADDR_W-1)'(1);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [BYTE_W-1:0] byte_lo_r;
    logic [HW_W-1:0]   lo_hw_r;
    logic              pend_r;
    logic [31:0]       pend_val_r;
    logic              pend_c_r;
    logic              inst_ready_r;
    logic              is_c_r;
    logic [31:0]       inst_val_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;

    logic              hi_phase_s;
    logic [ADDR_W-2:0] look_hw_s;
    logic              fill_s;
    logic [HW_W-1:0]   fill_data_s;
    logic              hit_s;
    logic [HW_W-1:0]   hw_s;

    // The lookup/fill address tracks the half being resolved: pc, or pc+2 with wrap-around.
    always_comb begin
        hi_phase_s  = (state_r == S_LOOK_HI) || (state_r == S_MISS_HI0) || (state_r == S_MISS_HI1);
        if (hi_phase_s) begin
            look_hw_s = pc_r[ADDR_W-1:1] + HW_ONE;
        end else begin
            look_hw_s = pc_r[ADDR_W-1:1];
        end
        fill_s      = rdy_in && !clear && mem_valid &&
                      ((state_r == S_MISS_LO1) || (state_r == S_MISS_HI1));
        fill_data_s = {mem_byte, byte_lo_r};
    end

    icache_hw #(
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_icache (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .rd_hw   (look_hw_s),
        .rd_hit  (hit_s),
        .rd_data (hw_s),
        .wr_en   (fill_s),
        .wr_hw   (look_hw_s),
        .wr_data (fill_data_s)
    );

    // Fetch FSM, memory handshake and the registered completion pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= S_IDLE;
            pc_r         <= '0;
            byte_lo_r    <= 8'h00;
            lo_hw_r      <= 16'h0000;
            pend_r       <= 1'b0;
            pend_val_r   <= 32'h0000_0000;
            pend_c_r     <= 1'b0;
            inst_ready_r <= 1'b0;
            is_c_r       <= 1'b0;
            inst_val_r   <= 32'h0000_0000;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= '0;
        end else if (rdy_in) begin
            // A completion decided last cycle is dropped if the pipeline flushes now.
            inst_ready_r <= pend_r && !clear;
            if (pend_r && !clear) begin
                inst_val_r <= pend_val_r;
                is_c_r     <= pend_c_r;
            end
            pend_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (if_enable && !clear && !pend_r) begin
                        pc_r    <= if_addr;
                        state_r <= S_LOOK_LO;
                    end
                end
                S_LOOK_LO: begin
                    if (clear) begin
                        state_r <= S_IDLE;
                    end else if (hit_s) begin
                        if (is_rvc(hw_s[1:0])) begin
                            pend_r     <= 1'b1;
                            pend_val_r <= {16'h0000, hw_s};
                            pend_c_r   <= 1'b1;
                            state_r    <= S_IDLE;
                        end else begin
                            lo_hw_r <= hw_s;
                            state_r <= S_LOOK_HI;
                        end
                    end else begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_r;
                        state_r    <= S_MISS_LO0;
                    end
                end
                S_LOOK_HI: begin
                    if (clear) begin
                        state_r <= S_IDLE;
                    end else if (hit_s) begin
                        pend_r     <= 1'b1;
                        pend_val_r <= {hw_s, lo_hw_r};
                        pend_c_r   <= 1'b0;
                        state_r    <= S_IDLE;
                    end else begin
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_r + A_TWO;
                        state_r    <= S_MISS_HI0;
                    end
                end
                S_MISS_LO0, S_MISS_HI0: begin
                    if (clear) begin
                        if (mem_req_r && !mem_valid) begin
                            state_r <= S_FLUSH;
                        end else begin
                            mem_req_r <= 1'b0;
                            state_r   <= S_IDLE;
                        end
                    end else if (mem_valid) begin
                        // Request stays up and simply moves on to the odd byte.
                        byte_lo_r  <= mem_byte;
                        mem_addr_r <= mem_addr_r + A_ONE;
                        state_r    <= (state_r == S_MISS_LO0) ? S_MISS_LO1 : S_MISS_HI1;
                    end
                end
                S_MISS_LO1, S_MISS_HI1: begin
                    if (clear) begin
                        if (mem_req_r && !mem_valid) begin
                            state_r <= S_FLUSH;
                        end else begin
                            mem_req_r <= 1'b0;
                            state_r   <= S_IDLE;
                        end
                    end else if (mem_valid) begin
                        mem_req_r <= 1'b0;
                        state_r   <= (state_r == S_MISS_LO1) ? S_LOOK_LO : S_LOOK_HI;
                    end
                end
                S_FLUSH: begin
                    if (mem_valid) begin
                        mem_req_r <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready = inst_ready_r;
    assign is_c       = is_c_r;
    assign inst_val   = inst_val_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: directed fetches, a byte-serial memory model,
// and a monitor that checks every inst_ready pulse against queued expectations.
module tb_inst_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        inst_ready;
    logic        is_c;
    logic [31:0] inst_val;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_byte;

    inst_fetcher #(.IDX_W(6), .ADDR_W(32)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .if_enable  (if_enable),
        .if_addr    (if_addr),
        .inst_ready (inst_ready),
        .is_c       (is_c),
        .inst_val   (inst_val),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_byte   (mem_byte)
    );

    logic [7:0]  mem_img [0:1023];
    logic [32:0] sb_q [$];
    logic [31:0] req_log [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ready_cnt = 0;
    int          ready_cyc = 0;
    int          t0 = 0;
    int          mem_lat = 1;
    logic        resp_busy = 1'b0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory controller model: one byte per request after mem_lat cycles, held until taken.
    initial begin
        logic [31:0] a;
        logic        taken;
        mem_valid = 1'b0;
        mem_byte  = 8'h00;
        forever begin
            @(posedge clk_in);
            #1;
            while (mem_req === 1'b1) begin
                resp_busy = 1'b1;
                a = mem_addr;
                req_log.push_back(a);
                for (int k = 1; k < mem_lat; k++) begin
                    @(posedge clk_in);
                    #1;
                end
                mem_valid = 1'b1;
                mem_byte  = mem_img[a[9:0]];
                do begin
                    @(posedge clk_in);
                    taken = rdy_in;
                    #1;
                end while (!taken);
                mem_valid = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    // Monitor: every inst_ready pulse must match the oldest expected instruction.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk_in);
            if (rst_in === 1'b1 && inst_ready === 1'b1) begin
                ready_cnt++;
                ready_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("unexpected_inst_ready", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("inst_val", inst_val, e[31:0]);
                    chk("is_c", {31'd0, is_c}, {31'd0, e[32]});
                end
            end
        end
    end

    task automatic issue(input logic [31:0] pc);
        @(negedge clk_in);
        if_addr   = pc;
        if_enable = 1'b1;
        t0        = cyc + 1;
        @(negedge clk_in);
        if_enable = 1'b0;
        #2;
    endtask

    task automatic wait_reqs(input int n);
        int w = 0;
        while (req_log.size() < n && w < 100) begin
            @(negedge clk_in);
            #2;
            w++;
        end
        chk("reqs_seen", {31'd0, req_log.size() >= n}, 32'd1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (resp_busy && w < 100) begin
            @(negedge clk_in);
            #2;
            w++;
        end
        chk("mem_idle", {31'd0, resp_busy}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ev, input logic ec,
                         input int nreq, input int exp_lat, input int stall);
        int          n = 0;
        int          rc0;
        int          st = stall;
        logic [31:0] held;
        req_log.delete();
        sb_q.push_back({ec, ev});
        rc0 = ready_cnt;
        issue(pc);
        while (ready_cnt == rc0 && n < 300) begin
            if (st > 0 && req_log.size() >= 1) begin
                rdy_in = 1'b0;
                held   = mem_addr;
                for (int k = 0; k < st; k++) begin
                    @(negedge clk_in);
                    #2;
                    chk("stall_mem_req", {31'd0, mem_req}, 32'd1);
                    chk("stall_mem_addr", mem_addr, held);
                end
                rdy_in = 1'b1;
                st     = 0;
            end
            @(negedge clk_in);
            #2;
            n++;
        end
        if (ready_cnt == rc0) begin
            chk("inst_ready_timeout", 32'd0, 32'd1);
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        end else begin
            chk("latency", ready_cyc - t0, exp_lat);
        end
        chk("req_count", req_log.size(), nreq);
        for (int i = 0; i < nreq && i < req_log.size(); i++) begin
            chk("req_addr", req_log[i], pc + i);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_inst_ready"}, {31'd0, inst_ready}, 32'd0);
        chk({tag, "_is_c"}, {31'd0, is_c}, 32'd0);
        chk({tag, "_inst_val"}, inst_val, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    endtask

    initial begin
        int rc0;
        for (int i = 0; i < 1024; i++) mem_img[i] = 8'h00;
        mem_img[0]     = 8'h93; mem_img[1]     = 8'h00; mem_img[2]     = 8'h50; mem_img[3]     = 8'h00;
        mem_img[4]     = 8'h05; mem_img[5]     = 8'h45;
        mem_img[6]     = 8'h13; mem_img[7]     = 8'h05; mem_img[8]     = 8'h01; mem_img[9]     = 8'h00;
        mem_img[32]    = 8'h13; mem_img[33]    = 8'h05; mem_img[34]    = 8'hA0; mem_img[35]    = 8'h00;
        mem_img[64]    = 8'h82; mem_img[65]    = 8'h80;
        mem_img[256]   = 8'h01; mem_img[257]   = 8'h45;

        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0; if_addr = 32'h0;
        repeat (3) @(negedge clk_in);
        #2;
        chk_zero_outputs("reset");
        @(negedge clk_in);
        rst_in = 1'b1;

        // Cold and warm fetches: 32-bit, compressed, and a 32-bit whose high half is cached.
        fetch(32'h0, 32'h0050_0093, 1'b0, 4, 9, 0);
        fetch(32'h0, 32'h0050_0093, 1'b0, 0, 3, 0);
        fetch(32'h4, 32'h0000_4505, 1'b1, 2, 5, 0);
        fetch(32'h4, 32'h0000_4505, 1'b1, 0, 2, 0);
        fetch(32'h8, 32'h0000_0001, 1'b1, 2, 5, 0);
        fetch(32'h6, 32'h0001_0513, 1'b0, 2, 6, 0);

        // Flush during the low lookup, then during the completion cycle: no pulse either time.
        rc0 = ready_cnt;
        issue(32'h4);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        repeat (4) @(negedge clk_in);
        #2;
        chk("no_ready_clear_look", ready_cnt, rc0);
        issue(32'h4);
        @(negedge clk_in);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        repeat (3) @(negedge clk_in);
        #2;
        chk("no_ready_clear_done", ready_cnt, rc0);
        fetch(32'h4, 32'h0000_4505, 1'b1, 0, 2, 0);

        // Asynchronous reset in the middle of a miss, then pc=0 must miss again.
        req_log.delete();
        issue(32'h60);
        wait_reqs(1);
        rst_in = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        repeat (3) @(negedge clk_in);
        wait_idle();
        @(negedge clk_in);
        rst_in = 1'b1;
        fetch(32'h0, 32'h0050_0093, 1'b0, 4, 9, 0);

        // Global stall for five cycles in the middle of a cold 32-bit miss.
        fetch(32'h20, 32'h00A0_0513, 1'b0, 4, 14, 5);

        // Flush with the second fill byte outstanding; the byte arrives three cycles later.
        mem_lat = 4;
        rc0 = ready_cnt;
        req_log.delete();
        issue(32'h40);
        wait_reqs(2);
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
        #2;
        wait_idle();
        repeat (2) @(negedge clk_in);
        #2;
        chk("no_ready_flush", ready_cnt, rc0);
        chk("flush_mem_req_low", {31'd0, mem_req}, 32'd0);
        chk("flush_req_count", req_log.size(), 32'd2);
        mem_lat = 1;
        fetch(32'h100, 32'h0000_4501, 1'b1, 2, 5, 0);
        fetch(32'h40, 32'h0000_8082, 1'b1, 2, 5, 0);

        repeat (3) @(negedge clk_in);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
